// File: rtl/r200_if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. Owns the PC and fetches one
// instruction at a time over a req/gnt/rvalid handshake.
module r200_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  pcsel,
    input  logic [31:0] pc_brtarg,
    input  logic [31:0] jump_imm,
    input  logic [31:0] jump_addimm,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_addrout,
    output logic [31:0] pcp4,
    output logic [31:0] instrn,
    output logic        instrn_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        req_q, req_d;
    logic        drop_q, drop_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pcp4_q, if_pcp4_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic        redirect_s;
    logic        accept_s;
    logic        to_ifid_s;
    logic        to_skid_s;
    logic [31:0] target_s;

    // Next-state logic for fetch FSM, skid buffer and IF/ID register.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drop_d       = drop_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_pcp4_d    = if_pcp4_q;
        if_instr_d   = if_instr_q;

        redirect_s = if_valid_q && (pcsel != 2'b00) && !stall;
        case (pcsel)
            2'b01:   target_s = pc_brtarg;
            2'b10:   target_s = jump_imm;
            2'b11:   target_s = jump_addimm & 32'hFFFF_FFFE;
            default: target_s = fetch_pc_q + 32'd4;
        endcase

        accept_s  = (state_q == ST_WAIT) && imem_rvalid && !drop_q;
        to_ifid_s = accept_s && !redirect_s && !stall && !skid_valid_q;
        to_skid_s = accept_s && !redirect_s && !to_ifid_s;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                    drop_d  = redirect_s;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response arriving alongside a redirect is wrong-path, same as a dropped one.
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_s) begin
                        state_d = ST_REQ;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = to_skid_s ? ST_HOLD : ST_REQ;
                    end
                end else if (redirect_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_HOLD: begin
                if (redirect_s || !stall) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (to_skid_s) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = fetch_pc_q;
            skid_instr_d = imem_rdata;
        end else begin
            skid_valid_d = skid_valid_d;
        end

        if (!stall) begin
            if (redirect_s) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end else if (skid_valid_q) begin
                if_valid_d   = 1'b1;
                if_pc_d      = skid_pc_q;
                if_pcp4_d    = skid_pc_q + 32'd4;
                if_instr_d   = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (to_ifid_s) begin
                if_valid_d = 1'b1;
                if_pc_d    = fetch_pc_q;
                if_pcp4_d  = fetch_pc_q + 32'd4;
                if_instr_d = imem_rdata;
            end else begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        end else begin
            if_valid_d = if_valid_q;
        end

        if (redirect_s) begin
            fetch_pc_d   = target_s;
            skid_valid_d = 1'b0;
        end else begin
            fetch_pc_d = fetch_pc_d;
        end

        req_d = (state_d == ST_REQ);
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_q        <= 1'b0;
            drop_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0000_0000;
            skid_instr_q <= NOP_INSTR;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0000_0000;
            if_pcp4_q    <= 32'h0000_0004;
            if_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_q        <= req_d;
            drop_q       <= drop_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_pcp4_q    <= if_pcp4_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = fetch_pc_q;
    assign pc_addrout   = if_pc_q;
    assign pcp4         = if_pcp4_q;
    assign instrn       = if_instr_q;
    assign instrn_valid = if_valid_q;

endmodule

// File: tb/tb_r200_if_stage.sv
// Bench for r200_if_stage: directed handshake sequences, a redirect-target table, and a
// randomized run checked against an in-order fetch-stream model.
module tb_r200_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pcsel;
    logic [31:0] pc_brtarg, jump_imm, jump_addimm;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req, instrn_valid;
    logic [31:0] imem_addr, pc_addrout, pcp4, instrn;

    logic        w_gnt, w_rvalid;
    logic [31:0] w_rdata;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_pcp4, w_instr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    r200_if_stage u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pcsel(pcsel),
        .pc_brtarg(pc_brtarg), .jump_imm(jump_imm), .jump_addimm(jump_addimm),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_addrout(pc_addrout), .pcp4(pcp4), .instrn(instrn), .instrn_valid(instrn_valid)
    );

    r200_if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .pcsel(2'b00),
        .pc_brtarg(32'h0000_0000), .jump_imm(32'h0000_0000), .jump_addimm(32'h0000_0000),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .pc_addrout(w_pc), .pcp4(w_pcp4), .instrn(w_instr), .instrn_valid(w_valid)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] brtarg;
        logic [31:0] jimm;
        logic [31:0] jaddimm;
        logic [31:0] exp_addr;
    } redir_vec_t;

    redir_vec_t vecs[6];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instrn_valid}, 32'd0);
        chk("rst_instr", instrn, NOP);
        chk("rst_pc", pc_addrout, 32'h0000_0000);
        chk("rst_pcp4", pcp4, 32'h0000_0004);
        chk("rst_w_req", {31'd0, w_req}, 32'd0);
        chk("rst_w_pcp4", w_pcp4, 32'h0000_0004);
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] exp_pc, tgt, prev_addr;
        logic        pend, prev_req_nogrant, prev_redir;
        logic [31:0] pend_addr;
        int          pend_cnt, consumed;

        vecs[0] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'h0000_0085, 32'h0000_0084};
        vecs[1] = '{2'b01, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 32'h0000_0200};
        vecs[2] = '{2'b10, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000, 32'h0000_1000};
        vecs[3] = '{2'b10, 32'h0000_0300, 32'h0000_0102, 32'h0000_0500, 32'h0000_0102};
        vecs[4] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[5] = '{2'b01, 32'h8000_0003, 32'h0000_0700, 32'h0000_0000, 32'h8000_0003};

        rst_n = 1'b0; stall = 1'b0; pcsel = 2'b00;
        pc_brtarg = 32'd0; jump_imm = 32'd0; jump_addimm = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'd0;
        step(); step();
        chk_reset_state();

        // Reset release, zero-wait grant, one-cycle response.
        rst_n = 1'b1;
        step();
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0000_0000);
        imem_gnt = 1'b1;
        step();
        chk("t1_req_wait", {31'd0, imem_req}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        chk("t1_instr", instrn, 32'h0050_0093);
        chk("t1_pc", pc_addrout, 32'h0000_0000);
        chk("t1_pcp4", pcp4, 32'h0000_0004);
        chk("t1_valid", {31'd0, instrn_valid}, 32'd1);
        chk("t1_addr4", imem_addr, 32'h0000_0004);

        // Stall while the PC 8 response arrives: skid holds it.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_f(32'd4);
        step();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; stall = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_f(32'd8);
        step();
        imem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("t2_no_req", {31'd0, imem_req}, 32'd0);
            chk("t2_hold_pc", pc_addrout, 32'h0000_0004);
            chk("t2_hold_instr", instrn, mem_f(32'd4));
            step();
        end
        stall = 1'b0;
        step();
        chk("t2_valid", {31'd0, instrn_valid}, 32'd1);
        chk("t2_pc8", pc_addrout, 32'h0000_0008);
        chk("t2_instr8", instrn, mem_f(32'd8));
        chk("t2_pcp4", pcp4, 32'h0000_000C);
        chk("t2_req12", {31'd0, imem_req}, 32'd1);
        chk("t2_addr12", imem_addr, 32'h0000_000C);

        // Branch redirect in the same cycle the request to 0x10 is granted.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_f(32'd12);
        step();
        imem_rvalid = 1'b0;
        chk("t3_pc12", pc_addrout, 32'h0000_000C);
        imem_gnt = 1'b1; pcsel = 2'b01; pc_brtarg = 32'h0000_0040;
        step();
        pcsel = 2'b00; imem_gnt = 1'b0;
        chk("t3_bubble_valid", {31'd0, instrn_valid}, 32'd0);
        chk("t3_bubble_instr", instrn, NOP);
        imem_rvalid = 1'b1; imem_rdata = mem_f(32'h10);
        step();
        imem_rvalid = 1'b0;
        chk("t3_dropped", {31'd0, instrn_valid}, 32'd0);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr40", imem_addr, 32'h0000_0040);

        // Redirect target table: each entry redirects from a REQ that has not been granted.
        cur = 32'h0000_0040;
        for (int i = 0; i < 6; i++) begin
            imem_gnt = 1'b1;
            step();
            imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_f(cur);
            step();
            imem_rvalid = 1'b0;
            chk("tab_pc", pc_addrout, cur);
            chk("tab_instr", instrn, mem_f(cur));
            pcsel = vecs[i].sel; pc_brtarg = vecs[i].brtarg;
            jump_imm = vecs[i].jimm; jump_addimm = vecs[i].jaddimm;
            step();
            pcsel = 2'b00;
            chk("tab_addr", imem_addr, vecs[i].exp_addr);
            chk("tab_req", {31'd0, imem_req}, 32'd1);
            chk("tab_bubble", {31'd0, instrn_valid}, 32'd0);
            cur = vecs[i].exp_addr;
        end

        // Reset in WAIT, late response ignored; wrap instance checks PC wraparound.
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr0", imem_addr, 32'h0000_0000);
        chk("t5_addr", w_addr, 32'hFFFF_FFFC);
        w_gnt = 1'b1;
        step();
        chk("t6_late_ignored", {31'd0, instrn_valid}, 32'd0);
        chk("t6_still_req", {31'd0, imem_req}, 32'd1);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = mem_f(32'hFFFF_FFFC);
        step();
        chk("t5_valid", {31'd0, w_valid}, 32'd1);
        chk("t5_pc", w_pc, 32'hFFFF_FFFC);
        chk("t5_pcp4", w_pcp4, 32'h0000_0000);
        chk("t5_addr_wrap", w_addr, 32'h0000_0000);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem_f(32'd0);
        w_rvalid = 1'b0; w_gnt = 1'b1;
        step();
        imem_rvalid = 1'b0;
        chk("t6_first_pc", pc_addrout, 32'h0000_0000);
        chk("t6_first_instr", instrn, mem_f(32'd0));
        w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = mem_f(32'd0);
        step();
        w_rvalid = 1'b0;
        chk("t5_pc2", w_pc, 32'h0000_0000);
        chk("t5_pcp4_2", w_pcp4, 32'h0000_0004);

        // Randomized run: consumed instructions must follow the program-order PC stream.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_pc = 32'h0000_0000;
        pend = 1'b0; pend_addr = 32'd0; pend_cnt = 0; consumed = 0;
        prev_req_nogrant = 1'b0; prev_redir = 1'b0; prev_addr = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (prev_req_nogrant && !prev_redir) begin
                chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            stall = ($urandom_range(0, 3) == 0);
            pc_brtarg = $urandom; jump_imm = $urandom; jump_addimm = $urandom;
            pcsel = 2'($urandom_range(0, 3));
            prev_redir = 1'b0;
            if (!instrn_valid) begin
                chk("rnd_nop", instrn, NOP);
            end else if (!stall) begin
                chk("rnd_pc", pc_addrout, exp_pc);
                chk("rnd_instr", instrn, mem_f(exp_pc));
                chk("rnd_pcp4", pcp4, exp_pc + 32'd4);
                consumed++;
                if ($urandom_range(0, 6) == 0) begin
                    tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                    pcsel = 2'($urandom_range(1, 3));
                    if (pcsel == 2'b01) pc_brtarg = tgt;
                    else if (pcsel == 2'b10) jump_imm = tgt;
                    else jump_addimm = tgt | {31'd0, 1'($urandom_range(0, 1))};
                    exp_pc = tgt;
                    prev_redir = 1'b1;
                end else begin
                    pcsel = 2'b00;
                    exp_pc = exp_pc + 32'd4;
                end
            end
            imem_rvalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem_f(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            imem_gnt = 1'b0;
            if (imem_req && ($urandom_range(0, 9) < 7)) begin
                imem_gnt = 1'b1;
                pend = 1'b1;
                pend_addr = imem_addr;
                pend_cnt = $urandom_range(0, 2);
            end
            prev_req_nogrant = imem_req && !imem_gnt;
            prev_addr = imem_addr;
        end
        total++;
        if (consumed < 150) begin
            bad++;
            $display("FAIL rnd_progress: got %0d instructions expected at least 150", consumed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
